// File: rtl/kanagawa_reorder_slot_allocator_if.sv
// Allocation handshake between a requester and the reorder slot allocator.
// The requester drives alloc_req/retire/flush; the allocator answers with ID offers.
interface kanagawa_reorder_slot_allocator_if #(
  parameter int LOG_DEPTH = 5
);
  logic                 alloc_req;
  logic                 alloc_valid;
  logic [LOG_DEPTH:0]   alloc_slot_id;
  logic                 retire;
  logic                 flush;

  modport master (
    output alloc_req,
    output retire,
    output flush,
    input  alloc_valid,
    input  alloc_slot_id
  );

  modport slave (
    input  alloc_req,
    input  retire,
    input  flush,
    output alloc_valid,
    output alloc_slot_id
  );
endinterface

// File: rtl/kanagawa_reorder_slot_allocator.sv
// Hands out reorder-buffer slot IDs (index + iteration bit) and tracks retires.
// Optional stall counter: define KANAGAWA_REORDER_SLOT_ALLOC_STATS_EN.
module kanagawa_reorder_slot_allocator #(
  parameter int LOG_DEPTH = 5
) (
  input  logic                   clock,
  input  logic                   rst,
  kanagawa_reorder_slot_allocator_if.slave bus,
  output logic [LOG_DEPTH:0]     outstanding,
  output logic                   busy,
`ifdef KANAGAWA_REORDER_SLOT_ALLOC_STATS_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic                   underflow_out
);
  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int SLOT_ID_WIDTH = LOG_DEPTH + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SLOT_ID_WIDTH-1:0] next_id_q, next_id_d;
  logic [LOG_DEPTH:0]       outstanding_q, outstanding_d;
  logic                     underflow_q, underflow_d;
  logic                     not_full;
  logic                     grant;
  logic                     retire_ok;
  logic                     out_zero;

  assign out_zero  = (outstanding_q == '0);
  assign not_full  = (outstanding_q < (LOG_DEPTH+1)'(DEPTH));
  assign bus.alloc_valid = !rst && (state_q == RUN) && not_full;
  assign grant     = bus.alloc_req && bus.alloc_valid;
  assign retire_ok = bus.retire && !out_zero;

  always_comb begin
    state_d       = state_q;
    next_id_d     = next_id_q;
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    if (grant)
      next_id_d = next_id_q + 1'b1;
    if (grant && !retire_ok)
      outstanding_d = outstanding_q + 1'b1;
    else if (!grant && retire_ok)
      outstanding_d = outstanding_q - 1'b1;
    if (bus.retire && out_zero)
      underflow_d = 1'b1;
    unique case (state_q)
      RUN: begin
        if (bus.flush)
          state_d = (out_zero && !grant) ? CLEAR : DRAIN;
      end
      DRAIN: begin
        if (out_zero)
          state_d = CLEAR;
      end
      CLEAR: begin
        next_id_d   = '0;
        underflow_d = 1'b0;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      next_id_q     <= '0;
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_id_q     <= next_id_d;
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
    end
  end

`ifdef KANAGAWA_REORDER_SLOT_ALLOC_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == CLEAR)
      stall_d = '0;
    else if (bus.alloc_req && !bus.alloc_valid && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  assign bus.alloc_slot_id = next_id_q;
  assign outstanding       = outstanding_q;
  assign busy              = (state_q != RUN);
  assign underflow_out     = underflow_q;
endmodule

// File: tb/tb_kanagawa_reorder_slot_allocator.sv
// Scoreboard bench for the reorder slot allocator.
// Stimulus queues expected IDs; a negedge monitor checks every grant.
module tb_kanagawa_reorder_slot_allocator;
  localparam int LD = 5;

  logic clock;
  logic rst;
  logic [LD:0] outstanding;
  logic busy;
  logic underflow_out;
`ifdef KANAGAWA_REORDER_SLOT_ALLOC_STATS_EN
  logic [31:0] stall_cycles;
`endif

  kanagawa_reorder_slot_allocator_if #(.LOG_DEPTH(LD)) bus ();

  kanagawa_reorder_slot_allocator #(.LOG_DEPTH(LD)) dut (
    .clock         (clock),
    .rst           (rst),
    .bus           (bus.slave),
    .outstanding   (outstanding),
    .busy          (busy),
`ifdef KANAGAWA_REORDER_SLOT_ALLOC_STATS_EN
    .stall_cycles  (stall_cycles),
`endif
    .underflow_out (underflow_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;
  int exp_id;
  logic [LD:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!rst && bus.alloc_req && bus.alloc_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_grant: got id %0d expected no grant",
                 bus.alloc_slot_id);
      end else begin
        logic [LD:0] e;
        e = exp_q.pop_front();
        if (bus.alloc_slot_id !== e) begin
          fails++;
          $display("FAIL grant_id: got %0d expected %0d",
                   bus.alloc_slot_id, e);
        end
      end
    end
  end

  task automatic step(input logic r, input logic ret,
                      input logic fl, input logic g);
    bus.alloc_req = r;
    bus.retire    = ret;
    bus.flush     = fl;
    if (g) begin
      exp_q.push_back(exp_id[LD:0]);
      exp_id = (exp_id + 1) % 64;
    end
    @(posedge clock);
    #1;
    bus.alloc_req = 1'b0;
    bus.retire    = 1'b0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    exp_id = 0;
    rst = 1'b1;
    bus.alloc_req = 1'b0;
    bus.retire    = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", bus.alloc_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_busy", busy, 0);
    check("rst_underflow", underflow_out, 0);
    check("rst_id", bus.alloc_slot_id, 0);
    rst = 1'b0;
    #1;
    check("run_valid", bus.alloc_valid, 1);

    for (int i = 0; i < 32; i++) step(1, 0, 0, 1);
    check("full_outstanding", outstanding, 32);
    check("full_valid", bus.alloc_valid, 0);
    step(1, 0, 0, 0);
    check("full_hold_id", bus.alloc_slot_id, 32);

    step(0, 1, 0, 0);
    check("refill_valid", bus.alloc_valid, 1);
    check("refill_outstanding", outstanding, 31);
    check("refill_id", bus.alloc_slot_id, 32);

    for (int i = 0; i < 32; i++) step(1, 1, 0, 1);
    check("wrap_id", bus.alloc_slot_id, 0);
    check("wrap_outstanding", outstanding, 31);

    for (int i = 0; i < 21; i++) step(0, 1, 0, 0);
    check("ten_outstanding", outstanding, 10);
    step(1, 1, 0, 1);
    check("same_cycle_outstanding", outstanding, 10);
    check("same_cycle_id", bus.alloc_slot_id, 1);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    check("five_outstanding", outstanding, 5);
    step(0, 0, 1, 0);
    check("flush_busy", busy, 1);
    check("flush_valid", bus.alloc_valid, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
    check("drain_outstanding", outstanding, 0);
    check("drain_busy", busy, 1);
    n = 0;
    while (busy && n < 6) begin
      step(0, 0, 0, 0);
      n++;
    end
    check("drain_timeout", busy, 0);
    check("post_clear_id", bus.alloc_slot_id, 0);
    check("post_clear_valid", bus.alloc_valid, 1);
    exp_id = 0;

    step(0, 1, 0, 0);
    check("under_outstanding", outstanding, 0);
    check("under_flag", underflow_out, 1);
    step(0, 0, 0, 0);
    check("under_sticky", underflow_out, 1);
    step(1, 0, 0, 1);
    step(0, 1, 0, 0);
    check("under_sticky2", underflow_out, 1);
    step(0, 0, 1, 0);
    check("clear_busy", busy, 1);
    step(0, 0, 0, 0);
    check("clear_underflow", underflow_out, 0);
    check("clear_done", busy, 0);
    check("clear_id", bus.alloc_slot_id, 0);
    exp_id = 0;

    for (int i = 0; i < 20; i++) step(1, 0, 0, 1);
    check("twenty_outstanding", outstanding, 20);
    check("twenty_id", bus.alloc_slot_id, 20);
    #2;
    rst = 1'b1;
    #1;
    check("async_outstanding", outstanding, 0);
    check("async_valid", bus.alloc_valid, 0);
    check("async_id", bus.alloc_slot_id, 0);
    check("async_busy", busy, 0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    exp_id = 0;
    step(1, 0, 0, 1);
    check("after_rst_id", bus.alloc_slot_id, 1);
    check("after_rst_outstanding", outstanding, 1);

    @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
